tmds_rx_decoder: RTL and testbench

TMDS_RX_DECODER -- requirements
Module: tmds_rx_decoder

---
 rtl/tmds_rx_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_tmds_rx_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_rx_decoder.sv
// TMDS receive decoder: common bit-offset word alignment, control/data decode, frame addressing.
// Optional: define TMDS_RX_ERRCNT_EN to enable the channel-disagreement counter on err_cnt.
module tmds_rx_decoder #(
  parameter int LOCK_RUN     = 8,
  parameter int SEARCH_WIN   = 64,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic        clk_low,
  input  logic        reset,
  input  logic [9:0]  sym_red,
  input  logic [9:0]  sym_green,
  input  logic [9:0]  sym_blue,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        locked,
  output logic [20:0] addr,
  output logic [15:0] err_cnt
);

  // state  | meaning
  // SEARCH | stepping the bit offset, looking for a run of blue control tokens
  // LOCKED | offset frozen, decoding; timeout watches for control runs
  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam int RUN_W = $clog2(LOCK_RUN + 1);
  localparam int WIN_W = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
  localparam int TMO_W = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

  function automatic logic is_token(input logic [9:0] q);
    return (q == 10'h354) || (q == 10'h0AB) || (q == 10'h154) || (q == 10'h2AB);
  endfunction

  function automatic logic [1:0] token_c(input logic [9:0] q);
    logic [1:0] c;
    case (q)
      10'h0AB: c = 2'b01;
      10'h154: c = 2'b10;
      10'h2AB: c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] q);
    logic [7:0] b;
    logic [7:0] d;
    b = q[9] ? ~q[7:0] : q[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    end
    return d;
  endfunction

  function automatic logic [9:0] align(input logic [19:0] w, input logic [3:0] o);
    logic [19:0] s;
    s = w >> o;
    return s[9:0];
  endfunction

  state_t             state;
  logic [3:0]         off;
  logic [RUN_W-1:0]   run;
  logic [RUN_W-1:0]   run_next;
  logic [WIN_W-1:0]   win_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [9:0]         cur_r, cur_g, cur_b;
  logic [9:0]         prev_r, prev_g, prev_b;
  logic [9:0]         al_r, al_g, al_b;
  logic               blue_tok;
  logic               run_full;
  logic               vsync_d;

  always_ff @(posedge clk_low) begin
    if (reset) begin
      cur_r  <= '0;
      cur_g  <= '0;
      cur_b  <= '0;
      prev_r <= '0;
      prev_g <= '0;
      prev_b <= '0;
    end else begin
      cur_r  <= sym_red;
      cur_g  <= sym_green;
      cur_b  <= sym_blue;
      prev_r <= cur_r;
      prev_g <= cur_g;
      prev_b <= cur_b;
    end
  end

  // Earlier-received word sits in the low half of the window.
  assign al_r = align({cur_r, prev_r}, off);
  assign al_g = align({cur_g, prev_g}, off);
  assign al_b = align({cur_b, prev_b}, off);

  assign blue_tok = is_token(al_b);

  always_comb begin
    run_next = '0;
    if (blue_tok) begin
      run_next = (run == RUN_W'(LOCK_RUN)) ? run : run + 1'b1;
    end
  end

  assign run_full = (run_next == RUN_W'(LOCK_RUN));

  always_ff @(posedge clk_low) begin
    if (reset) begin
      state   <= SEARCH;
      off     <= '0;
      run     <= '0;
      win_cnt <= '0;
      tmo_cnt <= '0;
      locked  <= 1'b0;
    end else begin
      locked <= (state == LOCKED);
      case (state)
        SEARCH: begin
          if (run_full) begin
            state   <= LOCKED;
            run     <= '0;
            win_cnt <= '0;
            tmo_cnt <= '0;
          end else if (win_cnt == WIN_W'(SEARCH_WIN - 1)) begin
            off     <= (off == 4'd9) ? 4'd0 : off + 4'd1;
            run     <= '0;
            win_cnt <= '0;
          end else begin
            run     <= run_next;
            win_cnt <= win_cnt + 1'b1;
          end
        end
        LOCKED: begin
          run <= run_next;
          if (run_full) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_W'(LOSS_TIMEOUT - 1)) begin
            state   <= SEARCH;
            run     <= '0;
            win_cnt <= '0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  // Gating on state (not locked) keeps the outputs in step with the registered locked flag.
  always_ff @(posedge clk_low) begin
    if (reset || state != LOCKED) begin
      de    <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else if (blue_tok) begin
      de    <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= token_c(al_b)[0];
      vsync <= token_c(al_b)[1];
    end else begin
      de    <= 1'b1;
      red   <= decode(al_r);
      green <= decode(al_g);
      blue  <= decode(al_b);
    end
  end

  always_ff @(posedge clk_low) begin
    if (reset) begin
      addr    <= '0;
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= vsync;
      if (vsync && !vsync_d) begin
        addr <= '0;
      end else if (de) begin
        addr <= addr + 21'd1;
      end
    end
  end

`ifdef TMDS_RX_ERRCNT_EN
  logic class_diff;
  assign class_diff = (is_token(al_r) != blue_tok) || (is_token(al_g) != blue_tok);

  always_ff @(posedge clk_low) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (locked && class_diff && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Self-checking bench for tmds_rx_decoder: alignment search, decode scoreboard, addressing, loss of lock.
module tb_tmds_rx_decoder;

  logic        clk_low = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  sym_red = '0;
  logic [9:0]  sym_green = '0;
  logic [9:0]  sym_blue = '0;
  logic [7:0]  red, green, blue;
  logic        de, hsync, vsync, locked;
  logic [20:0] addr;
  logic [15:0] err_cnt;

  tmds_rx_decoder dut (
    .clk_low  (clk_low),
    .reset    (reset),
    .sym_red  (sym_red),
    .sym_green(sym_green),
    .sym_blue (sym_blue),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .de       (de),
    .hsync    (hsync),
    .vsync    (vsync),
    .locked   (locked),
    .addr     (addr),
    .err_cnt  (err_cnt)
  );

  always #5 clk_low = ~clk_low;

  localparam logic [9:0] BLANK  = 10'h354;
  localparam logic [9:0] HS_TOK = 10'h0AB;
  localparam logic [9:0] VS_TOK = 10'h154;
  localparam logic [9:0] HV_TOK = 10'h2AB;

  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        de;
    logic        hs;
    logic        vs;
    logic [20:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  string       cur_test = "";
  logic        m_hs, m_vs, m_vs_prev;
  logic [20:0] m_addr;

  // {is_token, C1, C0}
  function automatic logic [2:0] m_tok(input logic [9:0] q);
    case (q)
      10'h354: return 3'b100;
      10'h0AB: return 3'b101;
      10'h154: return 3'b110;
      10'h2AB: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] m_dec(input logic [9:0] q);
    logic [7:0] b, d;
    b = q[7:0] ^ {8{q[9]}};
    d[0] = b[0];
    for (int i = 1; i < 8; i++) d[i] = b[i] ^ b[i-1] ^ ~q[8];
    return d;
  endfunction

  task automatic sb_pop();
    exp_t e, o;
    e = sb.pop_front();
    o.r = red; o.g = green; o.b = blue;
    o.de = de; o.hs = hsync; o.vs = vsync; o.addr = addr;
    n_checks++;
    if (o !== e)
      $display("FAIL %s scoreboard: got r=%h g=%h b=%h de=%b hs=%b vs=%b addr=%0d, want r=%h g=%h b=%h de=%b hs=%b vs=%b addr=%0d",
               cur_test, o.r, o.g, o.b, o.de, o.hs, o.vs, o.addr, e.r, e.g, e.b, e.de, e.hs, e.vs, e.addr);
    else
      n_pass++;
  endtask

  // Drive one word per lane at offset 0 and queue the output expected three edges later.
  task automatic send(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    exp_t e;
    logic [2:0] t;
    @(negedge clk_low);
    if (sb.size() >= 3) sb_pop();
    sym_red = r; sym_green = g; sym_blue = b;
    t = m_tok(b);
    if (t[2]) begin
      m_hs = t[0];
      m_vs = t[1];
    end
    e.r = t[2] ? 8'h00 : m_dec(r);
    e.g = t[2] ? 8'h00 : m_dec(g);
    e.b = t[2] ? 8'h00 : m_dec(b);
    e.de = ~t[2];
    e.hs = m_hs;
    e.vs = m_vs;
    e.addr = m_addr;
    if (e.vs && !m_vs_prev) m_addr = '0;
    else if (e.de) m_addr = m_addr + 21'd1;
    m_vs_prev = e.vs;
    sb.push_back(e);
  endtask

  task automatic blanks(input int n);
    for (int i = 0; i < n; i++) send(BLANK, BLANK, BLANK);
  endtask

  task automatic drain();
    repeat (3) begin
      @(negedge clk_low);
      if (sb.size() > 0) sb_pop();
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    reset = 1'b1;
    sym_red = 10'($urandom_range(0, 1023));
    sym_green = 10'($urandom_range(0, 1023));
    sym_blue = BLANK;
    repeat (3) @(negedge clk_low);
    n_checks++; if (locked !== 1'b0) $display("FAIL reset locked: got %b want 0", locked); else n_pass++;
    n_checks++; if (de !== 1'b0) $display("FAIL reset de: got %b want 0", de); else n_pass++;
    n_checks++; if ({red, green, blue} !== 24'h0) $display("FAIL reset rgb: got %h want 0", {red, green, blue}); else n_pass++;
    n_checks++; if ({hsync, vsync} !== 2'b00) $display("FAIL reset sync: got %b want 00", {hsync, vsync}); else n_pass++;
    n_checks++; if (addr !== 21'd0) $display("FAIL reset addr: got %0d want 0", addr); else n_pass++;
    n_checks++; if (err_cnt !== 16'd0) $display("FAIL reset err_cnt: got %0d want 0", err_cnt); else n_pass++;
  endtask

  task automatic test_lock_search();
    logic [9:0] w, s;
    int cnt;
    bit seen;
    cur_test = "lock_search";
    w = BLANK;
    s = {w[6:0], w[9:7]};
    @(negedge clk_low);
    sym_red = s; sym_green = s; sym_blue = s;
    reset = 1'b1;
    @(negedge clk_low);
    reset = 1'b0;
    cnt = 0;
    seen = 0;
    while (cnt < 300 && !seen) begin
      @(negedge clk_low);
      cnt++;
      if (cnt == 150) begin
        n_checks++; if (dut.off !== 4'd2) $display("FAIL search_offset: got %0d want 2", dut.off); else n_pass++;
        n_checks++; if ({locked, de} !== 2'b00) $display("FAIL search_unlocked: got locked,de=%b want 00", {locked, de}); else n_pass++;
      end
      if (locked) seen = 1;
    end
    n_checks++;
    if (!seen || cnt < 195 || cnt > 267) $display("FAIL lock_time: got %0d cycles (seen=%0d) want 195..267", cnt, seen);
    else n_pass++;
    n_checks++; if (dut.off !== 4'd3) $display("FAIL lock_offset: got %0d want 3", dut.off); else n_pass++;
  endtask

  task automatic test_reset_relock();
    int cnt;
    bit seen;
    cur_test = "reset_relock";
    @(negedge clk_low);
    reset = 1'b1;
    @(negedge clk_low);
    n_checks++; if (locked !== 1'b0) $display("FAIL reset_while_locked: got locked=%b want 0", locked); else n_pass++;
    n_checks++; if (dut.off !== 4'd0) $display("FAIL reset_offset: got %0d want 0", dut.off); else n_pass++;
    sym_red = BLANK; sym_green = BLANK; sym_blue = BLANK;
    reset = 1'b0;
    cnt = 0;
    seen = 0;
    while (cnt < 50 && !seen) begin
      @(negedge clk_low);
      cnt++;
      if (locked) seen = 1;
    end
    n_checks++;
    if (!seen || cnt < 10 || cnt > 14) $display("FAIL relock_time: got %0d cycles (seen=%0d) want 10..14", cnt, seen);
    else n_pass++;
    m_hs = 1'b0; m_vs = 1'b0; m_vs_prev = 1'b0; m_addr = '0;
    sb.delete();
  endtask

  task automatic test_errcnt();
    logic [15:0] want;
    cur_test = "errcnt";
`ifdef TMDS_RX_ERRCNT_EN
    want = 16'd5;
`else
    want = 16'd0;
`endif
    blanks(10);
    repeat (5) send(BLANK, 10'h1FF, BLANK);
    blanks(6);
    n_checks++;
    if (err_cnt !== want) $display("FAIL err_cnt: got %0d want %0d", err_cnt, want);
    else n_pass++;
  endtask

  task automatic test_control_tokens();
    cur_test = "control_tokens";
    blanks(8);
    send(HV_TOK, HV_TOK, HV_TOK);
    send(10'h1FF, 10'h100, 10'h2C3);
    send(10'h0F0, 10'h3A5, 10'h1FF);
    send(BLANK, BLANK, BLANK);
    send(HS_TOK, HS_TOK, HS_TOK);
    send(10'h155, 10'h2AA, 10'h333);
    send(VS_TOK, VS_TOK, VS_TOK);
    send(HV_TOK, HV_TOK, HV_TOK);
    blanks(8);
  endtask

  task automatic test_data_decode();
    logic [9:0] tbl [6];
    cur_test = "data_decode";
    tbl = '{10'h1FF, 10'h100, 10'h000, 10'h2FF, 10'h3AA, 10'h0C7};
    blanks(8);
    for (int i = 0; i < 6; i++) send(tbl[i], tbl[(i + 1) % 6], tbl[(i + 2) % 6]);
    for (int i = 0; i < 24; i++)
      send(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
    blanks(8);
  endtask

  task automatic test_back_to_back_frame();
    cur_test = "frame";
    repeat (8) send(VS_TOK, VS_TOK, VS_TOK);
    blanks(8);
    for (int line = 0; line < 3; line++) begin
      for (int px = 0; px < 16; px++)
        send(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 10'h1FF ^ 10'(px));
      repeat (10) send(HS_TOK, HS_TOK, HS_TOK);
    end
    repeat (8) send(VS_TOK, VS_TOK, VS_TOK);
    blanks(8);
    for (int px = 0; px < 5; px++) send(10'h0FF, 10'h2AA, 10'h1C0 + 10'(px));
    blanks(8);
    drain();
  endtask

  task automatic test_loss_of_lock();
    int cnt;
    bit dropped;
    cur_test = "loss";
    @(negedge clk_low);
    sym_red = 10'h1FF; sym_green = 10'h1FF; sym_blue = 10'h1FF;
    cnt = 0;
    dropped = 0;
    while (cnt < 4300 && !dropped) begin
      @(negedge clk_low);
      cnt++;
      if (!locked) dropped = 1;
    end
    n_checks++;
    if (!dropped || cnt < 4090 || cnt > 4110) $display("FAIL loss_time: got %0d cycles (dropped=%0d) want 4090..4110", cnt, dropped);
    else n_pass++;
    n_checks++; if (dut.off !== 4'd0) $display("FAIL loss_offset: got %0d want 0", dut.off); else n_pass++;
    n_checks++;
    if ({de, hsync, vsync, red, green, blue} !== 27'h0) $display("FAIL loss_forced: got de=%b rgb=%h want 0", de, {red, green, blue});
    else n_pass++;
    repeat (5) @(negedge clk_low);
    n_checks++;
    if ({locked, de, red, green, blue} !== 26'h0) $display("FAIL loss_stays_zero: got locked=%b de=%b rgb=%h want 0", locked, de, {red, green, blue});
    else n_pass++;
  endtask

  initial begin
    m_hs = 1'b0; m_vs = 1'b0; m_vs_prev = 1'b0; m_addr = '0;
    test_reset();
    test_lock_search();
    test_reset_relock();
    test_errcnt();
    test_control_tokens();
    test_data_decode();
    test_back_to_back_frame();
    test_loss_of_lock();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
